my_float_div: RTL and testbench
===============================

Name: my_float_div

Overview:
- Iterative half-precision (s|eeeee|ffffffffff) floating-point divider; the inverse operation to the team's pipelined float multiplier.
- Computes divIn1_44 / divIn2_44 with a restoring, one-quotient-bit-per-clock mantissa divider, then normalizes and rounds.
- Output word format and rounding rule match the multiplier, so results from the two blocks are directly comparable.
- Uses a start/busy/done handshake and fixed latency. It sits beside the multiplier in the datapath.

Parameters:
- REG_SIZE, 16, total word width
- EXP_SIZE, 5, exponent field width
- FRA_SIZE, 10, fraction field width (hidden 1 implied)
- BIAS, 15, exponent bias

Ports:
- clk_44  in  1  clock; all state changes on the rising edge
- reset_44  in  1  asynchronous, active-high reset
- divIn1_44  in  REG_SIZE  dividend
- divIn2_44  in  REG_SIZE  divisor
- start_44  in  1  request; sampled only in IDLE
- busy_44  out  1  high while a division is in progress
- divOut_44  out  REG_SIZE  quotient; holds its value until the next result
- d_o_44  out  1  result valid

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy_44=0, d_o_44=0, divOut_44=0, all internal registers 0. Reset asserted mid-division aborts the division; no result is produced.
- States: IDLE -> UNPACK -> DIVIDE -> NORM -> ROUND -> IDLE.
- IDLE: on start_44=1 at edge 0:
  - latch both operands;
  - busy_44<=1, d_o_44<=0;
  - go to UNPACK.
  - start_44 while busy_44=1 is ignored.
- UNPACK (edge 1):
  - sr = s1^s2.
  - Compute the signed exponent at width EXP_SIZE+2: ex = e1 - e2 + BIAS.
  - Remainder R = {1,f1}, divisor D = {1,f2}, both zero-extended to FRA_SIZE+2 bits.
  - Iteration counter = FRA_SIZE+3.
  - Classify special cases:
    - e2==0 && f2==0 -> divide-by-zero.
    - otherwise e1==0 -> zero result.
    - Any exponent field of 0 is treated as zero; no subnormal support.
- DIVIDE (edges 2..14, FRA_SIZE+3 = 13 cycles). Each cycle:
  - if R>=D: shift in quotient bit 1 and R <= (R-D)<<1;
  - else: shift in quotient bit 0 and R <= R<<1.
  - Q is 13 bits: Q[12] is the integer bit, Q[11:0] are fraction bits.
- NORM (edge 15):
  - if Q[12]==0: Q <= Q<<1 and ex <= ex-1;
  - otherwise hold.
- ROUND (edge 16):
  - mantissa = Q[11:2], guard bit = Q[1].
  - If guard==1, add 1 to the mantissa (round-half-up, same rule as the multiplier).
  - If rounding carries out of the mantissa: fraction=0, ex=ex+1.
  - Form divOut_44 = {sr, ex[EXP_SIZE-1:0], fraction}.
  - Overrides:
    - zero result -> {sr, 0, 0};
    - divide-by-zero -> {sr, all-ones, 0}.
  - d_o_44<=1, busy_44<=0, state -> IDLE.
- Latency: fixed at 16 clocks from the start-sampling edge to d_o_44 rising, special cases included. Back-to-back throughput is one result per 17 clocks.
- d_o_44 stays high until the next accepted start; it clears on that same edge. start_44 in the cycle d_o_44 is high is accepted.
- Operand changes after edge 0 have no effect on the running division.

Optional Feature:
- Macro: FLOAT_DIV_SATURATE_EN.
- Defined: after ROUND, the exponent is range-checked.
  - ex >= 2^EXP_SIZE-1 -> {sr, all-ones, 0} (infinity).
  - ex <= 0 -> {sr, 0, 0} (flush to zero).
- Undefined: the exponent field is ex modulo 2^EXP_SIZE (wraps), matching the multiplier's behaviour.

Test Plan:
- Reset, then 0x4600/0x4000 (6.0/2.0), start pulse -> busy_44 high for 16 clocks; at edge 16 divOut_44=0x4200, d_o_44=1.
- 0x3C00/0x4200 (1/3) -> 0x3555 (guard bit 0, no round). Then 0xBC00/0x3800 -> 0xC000.
- 0x3C00/0x3C40 (1/1.0625) -> 0x3B88 (guard bit 1, round-up path).
- 0x3C00/0x0000 -> 0x7C00. Then 0x0000/0x4000 -> 0x0000. Latency is still 16 in both cases.
- 0x7800/0x0C00 (overflow) -> 0x7C00 with FLOAT_DIV_SATURATE_EN, 0x2800 without.
- Start a division, assert reset_44 at edge 8 -> outputs immediately 0, no d_o_44. Start again -> correct result. A start pulse while busy_44=1 is ignored.

Source files
------------

// File: rtl/my_float_div.sv
// Iterative half-precision divider: restoring mantissa division, one quotient bit per clock, then normalize and round-half-up.
// Optional exponent range check (overflow -> infinity, underflow -> zero) enabled by defining FLOAT_DIV_SATURATE_EN.
module my_float_div #(
    parameter int REG_SIZE = 16,
    parameter int EXP_SIZE = 5,
    parameter int FRA_SIZE = 10,
    parameter int BIAS     = 15
) (
    input  logic                clk_44,
    input  logic                reset_44,
    input  logic [REG_SIZE-1:0] divIn1_44,
    input  logic [REG_SIZE-1:0] divIn2_44,
    input  logic                start_44,
    output logic                busy_44,
    output logic [REG_SIZE-1:0] divOut_44,
    output logic                d_o_44
);

    localparam int EX_W  = EXP_SIZE + 2;
    localparam int MAN_W = FRA_SIZE + 2;
    localparam int Q_W   = FRA_SIZE + 3;
    localparam int CNT_W = $clog2(FRA_SIZE + 4);
    localparam logic [EX_W-1:0]  BIAS_W = EX_W'(BIAS);
    localparam logic [CNT_W-1:0] ITERS  = CNT_W'(FRA_SIZE + 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_NORM,
        S_ROUND
    } state_t;

    state_t state, state_nxt;

    logic [REG_SIZE-1:0]    op_a, op_b;
    logic                   sr;
    logic signed [EX_W-1:0] ex;
    logic [MAN_W-1:0]       rem, dvs, rem_diff;
    logic [Q_W-1:0]         quo;
    logic [CNT_W-1:0]       cnt;
    logic                   is_dbz, is_zero;

    logic [FRA_SIZE:0]      man_sum;
    logic [EXP_SIZE-1:0]    exp_fld;
    logic [REG_SIZE-1:0]    result;
`ifdef FLOAT_DIV_SATURATE_EN
    localparam logic signed [EX_W-1:0] EX_MAX = EX_W'((1 << EXP_SIZE) - 1);
    logic signed [EX_W-1:0] ex_rnd;
`endif

    always_ff @(posedge clk_44 or posedge reset_44) begin
        if (reset_44) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_44) state_nxt = S_UNPACK;
            S_UNPACK: state_nxt = S_DIVIDE;
            S_DIVIDE: if (cnt == CNT_W'(1)) state_nxt = S_NORM;
            S_NORM:   state_nxt = S_ROUND;
            S_ROUND:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign rem_diff = rem - dvs;

    // Exponent field wraps modulo 2^EXP_SIZE unless the range check is built in.
    always_comb begin
        man_sum = {1'b0, quo[Q_W-2:2]} + {{FRA_SIZE{1'b0}}, quo[1]};
        exp_fld = ex[EXP_SIZE-1:0] + {{(EXP_SIZE-1){1'b0}}, man_sum[FRA_SIZE]};
        result  = {sr, exp_fld, man_sum[FRA_SIZE-1:0]};
`ifdef FLOAT_DIV_SATURATE_EN
        ex_rnd = ex + $signed({{(EX_W-1){1'b0}}, man_sum[FRA_SIZE]});
        if (ex_rnd >= EX_MAX)
            result = {sr, {EXP_SIZE{1'b1}}, {FRA_SIZE{1'b0}}};
        else if (ex_rnd <= 0)
            result = {sr, {(REG_SIZE-1){1'b0}}};
`endif
        if (is_dbz)
            result = {sr, {EXP_SIZE{1'b1}}, {FRA_SIZE{1'b0}}};
        else if (is_zero)
            result = {sr, {(REG_SIZE-1){1'b0}}};
    end

    always_ff @(posedge clk_44 or posedge reset_44) begin
        if (reset_44) begin
            op_a      <= '0;
            op_b      <= '0;
            sr        <= 1'b0;
            ex        <= '0;
            rem       <= '0;
            dvs       <= '0;
            quo       <= '0;
            cnt       <= '0;
            is_dbz    <= 1'b0;
            is_zero   <= 1'b0;
            busy_44   <= 1'b0;
            d_o_44    <= 1'b0;
            divOut_44 <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_44) begin
                        op_a    <= divIn1_44;
                        op_b    <= divIn2_44;
                        busy_44 <= 1'b1;
                        d_o_44  <= 1'b0;
                    end
                end
                S_UNPACK: begin
                    sr  <= op_a[REG_SIZE-1] ^ op_b[REG_SIZE-1];
                    ex  <= {2'b00, op_a[REG_SIZE-2 -: EXP_SIZE]}
                         - {2'b00, op_b[REG_SIZE-2 -: EXP_SIZE]} + BIAS_W;
                    rem <= {2'b01, op_a[FRA_SIZE-1:0]};
                    dvs <= {2'b01, op_b[FRA_SIZE-1:0]};
                    quo <= '0;
                    cnt <= ITERS;
                    is_dbz  <= (op_b[REG_SIZE-2 -: EXP_SIZE] == '0) && (op_b[FRA_SIZE-1:0] == '0);
                    is_zero <= (op_a[REG_SIZE-2 -: EXP_SIZE] == '0);
                end
                S_DIVIDE: begin
                    cnt <= cnt - 1'b1;
                    if (rem >= dvs) begin
                        quo <= {quo[Q_W-2:0], 1'b1};
                        rem <= {rem_diff[MAN_W-2:0], 1'b0};
                    end else begin
                        quo <= {quo[Q_W-2:0], 1'b0};
                        rem <= {rem[MAN_W-2:0], 1'b0};
                    end
                end
                S_NORM: begin
                    if (!quo[Q_W-1]) begin
                        quo <= {quo[Q_W-2:0], 1'b0};
                        ex  <= ex - 1'b1;
                    end
                end
                S_ROUND: begin
                    divOut_44 <= result;
                    d_o_44    <= 1'b1;
                    busy_44   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_my_float_div.sv
// Self-checking bench for my_float_div: directed vectors, handshake/latency checks, mid-division reset, and randomized operands against an arithmetic reference.
module tb_my_float_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din1 = '0;
    logic [15:0] din2 = '0;
    logic        start = 1'b0;
    logic        busy;
    logic [15:0] dout;
    logic        d_o;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FLOAT_DIV_SATURATE_EN
    localparam logic [15:0] OVF_EXP = 16'h7C00;
`else
    localparam logic [15:0] OVF_EXP = 16'h2800;
`endif

    always #5 clk = ~clk;

    my_float_div #(
        .REG_SIZE(16),
        .EXP_SIZE(5),
        .FRA_SIZE(10),
        .BIAS(15)
    ) dut (
        .clk_44(clk),
        .reset_44(rst),
        .divIn1_44(din1),
        .divIn2_44(din2),
        .start_44(start),
        .busy_44(busy),
        .divOut_44(dout),
        .d_o_44(d_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer quotient of the significands, then normalize and round half up.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        int e1, e2, f1, f2, q, ex, m;
        logic sr;
        sr = a[15] ^ b[15];
        e1 = int'(a[14:10]);
        e2 = int'(b[14:10]);
        f1 = int'(a[9:0]);
        f2 = int'(b[9:0]);
        if (e2 == 0 && f2 == 0) return {sr, 5'h1F, 10'h000};
        if (e1 == 0) return {sr, 15'h0000};
        q  = ((1024 + f1) * 4096) / (1024 + f2);
        ex = e1 - e2 + 15;
        if (q < 4096) begin
            q  = q * 2;
            ex = ex - 1;
        end
        m = (q / 4) + ((q / 2) % 2);
        if (m >= 2048) begin
            m  = m / 2;
            ex = ex + 1;
        end
`ifdef FLOAT_DIV_SATURATE_EN
        if (ex >= 31) return {sr, 5'h1F, 10'h000};
        if (ex <= 0)  return {sr, 15'h0000};
`endif
        return {sr, 5'(ex & 31), 10'(m - 1024)};
    endfunction

    task automatic run_div(input logic [15:0] a, input logic [15:0] b, input bit poke,
                           output logic [15:0] res);
        int n;
        @(negedge clk);
        din1  = a;
        din2  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        din1  = 16'($urandom);
        din2  = 16'($urandom);
        check("busy_on", busy, 1);
        check("done_clr", d_o, 0);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 4) begin
                start = 1'b1;
                din1  = 16'h4000;
                din2  = 16'h3C00;
            end
            if (poke && n == 5) start = 1'b0;
            if (d_o) break;
            check("busy_run", busy, 1);
        end
        check("latency", n, 16);
        check("busy_off", busy, 0);
        res = dout;
    endtask

    logic [15:0] vec_a [7] = '{16'h4600, 16'h3C00, 16'hBC00, 16'h3C00, 16'h3C00, 16'h0000, 16'h7800};
    logic [15:0] vec_b [7] = '{16'h4000, 16'h4200, 16'h3800, 16'h3C40, 16'h0000, 16'h4000, 16'h0C00};
    logic [15:0] vec_q [7] = '{16'h4200, 16'h3555, 16'hC000, 16'h3B88, 16'h7C00, 16'h0000, OVF_EXP};

    initial begin
        logic [15:0] res, a, b;
        int d_o_seen;

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", d_o, 0);
        check("rst_out", dout, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_div(vec_a[i], vec_b[i], 1'b0, res);
            check($sformatf("dir%0d", i), res, vec_q[i]);
        end

        // Output and valid hold while idle.
        repeat (3) @(negedge clk);
        check("hold_done", d_o, 1);
        check("hold_out", dout, OVF_EXP);

        // Reset in the middle of a division.
        @(negedge clk);
        din1  = 16'h4600;
        din2  = 16'h4000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", d_o, 0);
        check("mid_rst_out", dout, 0);
        @(negedge clk);
        rst = 1'b0;
        d_o_seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (d_o) d_o_seen++;
        end
        check("mid_rst_no_done", d_o_seen, 0);
        run_div(16'h4600, 16'h4000, 1'b0, res);
        check("after_rst", res, 16'h4200);

        // Start pulse during busy must not disturb or queue a division.
        run_div(16'h3C00, 16'h4200, 1'b1, res);
        check("poke_res", res, 16'h3555);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("poke_idle", busy, 0);
        end

        // Randomized back-to-back divisions.
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 9))
                0: b = {b[15], 15'h0000};
                1: a[14:10] = 5'h00;
                default: ;
            endcase
            if (b[14:10] == 5'h00) b[9:0] = 10'h000;
            run_div(a, b, 1'b0, res);
            check($sformatf("rnd %h/%h", a, b), res, model(a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
